// File: rtl/sprite_cmd_pkg.sv
// -----------------------------------------------------------------------------
// sprite_cmd_pkg
// Definitions shared by the sprite command encoder and its request FIFO:
//   - bit positions of the 32-bit command word fields
//   - action and type codes
//   - sprite_req_t, the buffered sprite update request
//   - state_t, the encoder FSM states
//   - make_word() packs fields into a command word
//   - next_emit_state() finds the next update word selected by a request mask
// -----------------------------------------------------------------------------
package sprite_cmd_pkg;

    // Command word layout: [31:26] component, [25:21] zero, [20:17] action,
    // [16:14] type, [13] buffer toggle, [12:0] data.
    localparam int COMP_LSB   = 26;
    localparam int ACT_LSB    = 17;
    localparam int TYPE_LSB   = 14;
    localparam int TOGGLE_BIT = 13;
    localparam int DATA_W     = 13;

    localparam logic [3:0] ACT_UPDATE = 4'b0001;
    localparam logic [3:0] ACT_COMMIT = 4'b1111;

    localparam logic [2:0] TYPE_NONE = 3'b000;
    localparam logic [2:0] TYPE_VIS  = 3'b001;
    localparam logic [2:0] TYPE_X    = 3'b010;
    localparam logic [2:0] TYPE_Y    = 3'b011;
    localparam logic [2:0] TYPE_ATTR = 3'b100;

    typedef struct packed {
        logic [5:0] component;
        logic [3:0] mask;       // [0] vis/pattern, [1] X, [2] Y, [3] attr
        logic       visible;
        logic       flip;
        logic [4:0] pattern;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] attr;
    } sprite_req_t;

    // Emitting states are numbered so that the encoding of a state equals the
    // index of the next mask bit to consider once that state's word is done.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VIS    = 3'd1,
        ST_XPOS   = 3'd2,
        ST_YPOS   = 3'd3,
        ST_ATTR   = 3'd4,
        ST_COMMIT = 3'd5
    } state_t;

    function automatic logic [31:0] make_word(
        input logic [5:0]        comp,
        input logic [3:0]        act,
        input logic [2:0]        typ,
        input logic              toggle,
        input logic [DATA_W-1:0] data
    );
        logic [31:0] w;
        w                    = '0;
        w[COMP_LSB +: 6]     = comp;
        w[ACT_LSB +: 4]      = act;
        w[TYPE_LSB +: 3]     = typ;
        w[TOGGLE_BIT]        = toggle;
        w[DATA_W-1:0]        = data;
        return w;
    endfunction

    // First emitting state whose mask bit index is >= start; ST_IDLE if none.
    // Later assignments have priority, so the lowest qualifying bit wins.
    function automatic state_t next_emit_state(
        input logic [3:0] mask,
        input logic [2:0] start
    );
        state_t ns;
        ns = ST_IDLE;
        if (mask[3] && start <= 3'd3) ns = ST_ATTR;
        if (mask[2] && start <= 3'd2) ns = ST_YPOS;
        if (mask[1] && start <= 3'd1) ns = ST_XPOS;
        if (mask[0] && start == 3'd0) ns = ST_VIS;
        return ns;
    endfunction

endpackage

// File: rtl/sprite_cmd_encoder_fifo.sv
// -----------------------------------------------------------------------------
// sprite_req_fifo
// Synchronous FIFO of sprite_req_t requests with full/empty flags.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push_i, push_data_i   write request; ignored while full
//   pop_i,  pop_data_o    read request; pop_data_o shows the head entry
//   full_o, empty_o       occupancy flags, decoded from the registered count
// A push and pop in the same cycle while full: only the pop takes effect,
// because full_o depends solely on the registered count.
// -----------------------------------------------------------------------------
module sprite_req_fifo
    import sprite_cmd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push_i,
    input  sprite_req_t push_data_i,
    input  logic        pop_i,
    output sprite_req_t pop_data_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(DEPTH);

    sprite_req_t      mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o     = (count_q == (AW+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem[rd_ptr_q];

    // Storage has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/sprite_cmd_encoder.sv
// -----------------------------------------------------------------------------
// sprite_cmd_encoder
// Turns sprite update requests into 32-bit command words for the display
// blocks and inserts one buffer-commit word per frame start.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   req_*                 valid/ready request input (buffered in a FIFO)
//   frame_start           one-cycle pulse at vblank start
//   out_ready             downstream may accept a word this cycle
//   wr_en, writedata      registered command word output
//   back_sel              buffer currently being written
//   commit_overrun        sticky: a frame_start arrived with a commit pending
// Build option: define SPRITE_CMD_STATS_EN to add stat_words (accepted words)
// and stat_frames (accepted commits) wrapping counters.
// -----------------------------------------------------------------------------
module sprite_cmd_encoder
    import sprite_cmd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_component,
    input  logic [3:0]  req_mask,
    input  logic        req_visible,
    input  logic        req_flip,
    input  logic [4:0]  req_pattern,
    input  logic [9:0]  req_x,
    input  logic [9:0]  req_y,
    input  logic [9:0]  req_attr,
    input  logic        frame_start,
    input  logic        out_ready,
    output logic        wr_en,
    output logic [31:0] writedata,
    output logic        back_sel,
    output logic        commit_overrun
`ifdef SPRITE_CMD_STATS_EN
    ,
    output logic [15:0] stat_words,
    output logic [15:0] stat_frames
`endif
);

    sprite_req_t req_in;
    sprite_req_t fifo_rdata;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;

    state_t      state_q;
    sprite_req_t hold_q;
    logic        wr_en_q;
    logic [31:0] writedata_q;
    logic        back_sel_q;
    logic        commit_pending_q;
    logic        commit_pending_d;
    logic        overrun_q;
    logic        overrun_d;

    logic        word_accept;
    logic        commit_accept;
    logic [2:0]  state_idx;
    state_t      after_state;

    assign req_in = '{component: req_component, mask: req_mask,
                      visible: req_visible, flip: req_flip,
                      pattern: req_pattern, x: req_x, y: req_y,
                      attr: req_attr};

    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    // Commit has priority; a request is only taken between whole requests.
    assign fifo_pop  = (state_q == ST_IDLE) && !commit_pending_q && !fifo_empty;

    sprite_req_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (reset_n),
        .push_i     (fifo_push),
        .push_data_i(req_in),
        .pop_i      (fifo_pop),
        .pop_data_o (fifo_rdata),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    assign word_accept   = wr_en_q && out_ready;
    assign commit_accept = word_accept && (state_q == ST_COMMIT);
    assign state_idx     = state_q;
    assign after_state   = next_emit_state(hold_q.mask, state_idx);

    // A pulse in the accepting cycle starts a fresh pending commit; any other
    // pulse while pending is folded into the existing one and flagged.
    always_comb begin
        commit_pending_d = commit_pending_q;
        overrun_d        = overrun_q;
        if (commit_accept) begin
            commit_pending_d = frame_start;
        end else if (frame_start) begin
            if (commit_pending_q) overrun_d = 1'b1;
            commit_pending_d = 1'b1;
        end
    end

    function automatic logic [31:0] word_for(
        input state_t      st,
        input sprite_req_t r,
        input logic        bs
    );
        logic [31:0] w;
        case (st)
            ST_VIS:    w = make_word(r.component, ACT_UPDATE, TYPE_VIS, bs,
                                     {r.visible, r.flip, 6'b0, r.pattern});
            ST_XPOS:   w = make_word(r.component, ACT_UPDATE, TYPE_X, bs, {3'b0, r.x});
            ST_YPOS:   w = make_word(r.component, ACT_UPDATE, TYPE_Y, bs, {3'b0, r.y});
            ST_ATTR:   w = make_word(r.component, ACT_UPDATE, TYPE_ATTR, bs, {3'b0, r.attr});
            ST_COMMIT: w = make_word(6'd0, ACT_COMMIT, TYPE_NONE, bs, '0);
            default:   w = '0;
        endcase
        return w;
    endfunction

    // Entering an emitting state, the first cycle loads the output register;
    // afterwards each accepted word directly loads the following one so that
    // words stream back-to-back while out_ready stays high.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            hold_q           <= '0;
            wr_en_q          <= 1'b0;
            writedata_q      <= '0;
            back_sel_q       <= 1'b1;
            commit_pending_q <= 1'b0;
            overrun_q        <= 1'b0;
        end else begin
            commit_pending_q <= commit_pending_d;
            overrun_q        <= overrun_d;
            case (state_q)
                ST_IDLE: begin
                    if (commit_pending_q) begin
                        state_q <= ST_COMMIT;
                    end else if (!fifo_empty) begin
                        // A popped request with an empty mask yields ST_IDLE
                        // and is dropped.
                        hold_q  <= fifo_rdata;
                        state_q <= next_emit_state(fifo_rdata.mask, 3'd0);
                    end
                end
                ST_COMMIT: begin
                    if (!wr_en_q) begin
                        wr_en_q     <= 1'b1;
                        writedata_q <= word_for(ST_COMMIT, hold_q, back_sel_q);
                    end else if (out_ready) begin
                        wr_en_q    <= 1'b0;
                        back_sel_q <= ~back_sel_q;
                        state_q    <= ST_IDLE;
                    end
                end
                default: begin
                    if (!wr_en_q) begin
                        wr_en_q     <= 1'b1;
                        writedata_q <= word_for(state_q, hold_q, back_sel_q);
                    end else if (out_ready) begin
                        state_q <= after_state;
                        if (after_state == ST_IDLE) begin
                            wr_en_q <= 1'b0;
                        end else begin
                            writedata_q <= word_for(after_state, hold_q, back_sel_q);
                        end
                    end
                end
            endcase
        end
    end

    assign wr_en          = wr_en_q;
    assign writedata      = writedata_q;
    assign back_sel       = back_sel_q;
    assign commit_overrun = overrun_q;

`ifdef SPRITE_CMD_STATS_EN
    logic [15:0] stat_words_q;
    logic [15:0] stat_frames_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_words_q  <= '0;
            stat_frames_q <= '0;
        end else begin
            if (word_accept)   stat_words_q  <= stat_words_q + 16'd1;
            if (commit_accept) stat_frames_q <= stat_frames_q + 16'd1;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_frames = stat_frames_q;
`endif

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
module tb_sprite_cmd_encoder;

    localparam int FIFO_DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_component;
    logic [3:0]  req_mask;
    logic        req_visible;
    logic        req_flip;
    logic [4:0]  req_pattern;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic [9:0]  req_attr;
    logic        frame_start;
    logic        out_ready;
    logic        wr_en;
    logic [31:0] writedata;
    logic        back_sel;
    logic        commit_overrun;
`ifdef SPRITE_CMD_STATS_EN
    logic [15:0] stat_words;
    logic [15:0] stat_frames;
`endif

    always #5 clk = ~clk;

    sprite_cmd_encoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_component (req_component),
        .req_mask      (req_mask),
        .req_visible   (req_visible),
        .req_flip      (req_flip),
        .req_pattern   (req_pattern),
        .req_x         (req_x),
        .req_y         (req_y),
        .req_attr      (req_attr),
        .frame_start   (frame_start),
        .out_ready     (out_ready),
        .wr_en         (wr_en),
        .writedata     (writedata),
        .back_sel      (back_sel),
        .commit_overrun(commit_overrun)
`ifdef SPRITE_CMD_STATS_EN
        ,
        .stat_words    (stat_words),
        .stat_frames   (stat_frames)
`endif
    );

    // ------------------------------------------------------------------
    // Reference model: requests as plain integers, words built arithmetically
    // ------------------------------------------------------------------
    typedef struct {
        int comp, mask, vis, flip, pat, x, y, attr;
    } req_t;

    req_t        m_q[$];
    req_t        cur;
    bit          cur_active;
    int          cur_idx;
    int          m_back_sel;
    bit          m_pending;
    bit          m_overrun;
    int          n_commits;
    int          n_pushed;
    int          cycle;
    logic [31:0] log_words[$];
    int          log_cycle[$];
    bit          hold_pending;
    logic [31:0] held_word;
    bit          ready_s;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] upd_word(input req_t r, input int idx, input int bs);
        longint data;
        longint w;
        case (idx)
            0:       data = r.vis * 4096 + r.flip * 2048 + r.pat;
            1:       data = r.x;
            2:       data = r.y;
            default: data = r.attr;
        endcase
        w = longint'(r.comp) * 67108864 + 131072 + longint'(idx + 1) * 16384 + bs * 8192 + data;
        return 32'(w);
    endfunction

    function automatic logic [31:0] commit_word(input int bs);
        return 32'(15 * 131072 + bs * 8192);
    endfunction

    function automatic int next_idx(input req_t r, input int from);
        for (int i = from; i < 4; i++) begin
            if (((r.mask >> i) & 1) == 1) return i;
        end
        return 4;
    endfunction

    function automatic int pending_reqs();
        int n = 0;
        foreach (m_q[i]) if (m_q[i].mask != 0) n++;
        return n;
    endfunction

    task automatic model_word(input logic [31:0] w);
        logic [31:0] exp;
        log_words.push_back(w);
        log_cycle.push_back(cycle);
        $display("[TB] word 0x%08h cycle %0d", w, cycle);
        if (cur_active) begin
            exp = upd_word(cur, cur_idx, m_back_sel);
            check_eq("update_word", w, exp);
            cur_idx    = next_idx(cur, cur_idx + 1);
            cur_active = (cur_idx < 4);
        end else if (m_pending && w === commit_word(m_back_sel)) begin
            m_back_sel = 1 - m_back_sel;
            m_pending  = 1'b0;
            n_commits++;
        end else begin
            while (m_q.size() > 0 && m_q[0].mask == 0) void'(m_q.pop_front());
            if (m_q.size() == 0) begin
                check_eq("spurious_word", m_q.size(), 1);
            end else begin
                cur     = m_q.pop_front();
                cur_idx = next_idx(cur, 0);
                exp     = upd_word(cur, cur_idx, m_back_sel);
                check_eq("first_word", w, exp);
                cur_idx    = next_idx(cur, cur_idx + 1);
                cur_active = (cur_idx < 4);
            end
        end
    endtask

    // Monitor: inputs change at posedge+1, so at negedge every signal holds
    // exactly what the coming posedge will sample.
    always @(negedge clk) begin
        if (!reset_n) begin
            m_q.delete();
            cur_active   = 1'b0;
            m_back_sel   = 1;
            m_pending    = 1'b0;
            m_overrun    = 1'b0;
            hold_pending = 1'b0;
            ready_s      = 1'b0;
        end else begin
            cycle++;
            ready_s = req_ready;
            if (hold_pending) begin
                check_eq("hold_wr_en", wr_en, 1);
                check_eq("hold_data", writedata, held_word);
            end
            check_eq("back_sel", back_sel, 32'(m_back_sel));
            check_eq("overrun", commit_overrun, m_overrun);
            if (req_valid && req_ready) begin
                m_q.push_back('{int'(req_component), int'(req_mask), int'(req_visible),
                                int'(req_flip), int'(req_pattern), int'(req_x),
                                int'(req_y), int'(req_attr)});
                n_pushed++;
            end
            if (wr_en && out_ready) model_word(writedata);
            hold_pending = wr_en && !out_ready;
            held_word    = writedata;
            if (frame_start) begin
                if (m_pending) m_overrun = 1'b1;
                m_pending = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive_req(input req_t r);
        req_component = 6'(r.comp);
        req_mask      = 4'(r.mask);
        req_visible   = 1'(r.vis);
        req_flip      = 1'(r.flip);
        req_pattern   = 5'(r.pat);
        req_x         = 10'(r.x);
        req_y         = 10'(r.y);
        req_attr      = 10'(r.attr);
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.comp = $urandom_range(63);
        r.mask = $urandom_range(15);
        r.vis  = $urandom_range(1);
        r.flip = $urandom_range(1);
        r.pat  = $urandom_range(31);
        r.x    = $urandom_range(1023);
        r.y    = $urandom_range(1023);
        r.attr = $urandom_range(1023);
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the transfer edge.
    task automatic push_req(input req_t r);
        bit ok = 1'b0;
        drive_req(r);
        req_valid = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk); #1;
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("push_accepted", ok, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic wait_wr_en(input string tag);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk); #1;
            if (wr_en) break;
        end
        check_eq(tag, wr_en, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_words(input string tag, input int target);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk); #1;
            if (log_words.size() >= target) break;
        end
        check_eq(tag, log_words.size(), target);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk); #1;
            if (pending_reqs() == 0 && !cur_active && !m_pending && !wr_en && !req_valid) begin
                done = 1'b1;
                break;
            end
        end
        check_eq(tag, done, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin
        req_t r;
        int   base;
        int   np0;
        int   c0;

        reset_n     = 1'b0;
        req_valid   = 1'b0;
        frame_start = 1'b0;
        out_ready   = 1'b0;
        r = '{0, 0, 0, 0, 0, 0, 0, 0};
        drive_req(r);
        n_commits = 0;
        n_pushed  = 0;
        cycle     = 0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Reset state
        @(negedge clk); #1;
        check_eq("rst_wr_en", wr_en, 0);
        check_eq("rst_back_sel", back_sel, 1);
        check_eq("rst_req_ready", req_ready, 1);
        check_eq("rst_writedata", writedata, 0);
        check_eq("rst_overrun", commit_overrun, 0);
        @(posedge clk); #1;

        // Two-word request streamed back-to-back
        out_ready = 1'b1;
        base = log_words.size();
        push_req('{8, 4'b0011, 1, 0, 0, 100, 7, 9});
        wait_words("t2_words", base + 2);
        if (log_words.size() >= base + 2) begin
            check_eq("t2_word0", log_words[base], 32'h20027000);
            check_eq("t2_word1", log_words[base + 1], 32'h2002A064);
            check_eq("t2_consecutive", log_cycle[base + 1] - log_cycle[base], 1);
        end

        // frame_start during a full request: commit comes after all 4 words
        r = rand_req();
        r.comp = 5;
        r.mask = 15;
        base = log_words.size();
        push_req(r);
        wait_wr_en("t3_wr_en");
        pulse_frame();
        wait_words("t3_words", base + 5);
        if (log_words.size() >= base + 5) begin
            for (int i = 0; i < 4; i++)
                check_eq("t3_type_order", (log_words[base + i] >> 14) & 7, i + 1);
            check_eq("t3_commit", log_words[base + 4], 32'h001E2000);
        end
        @(negedge clk); #1;
        check_eq("t3_back_sel", back_sel, 0);
        @(posedge clk); #1;
        r = rand_req();
        r.mask = 4'b0010;
        base = log_words.size();
        push_req(r);
        wait_words("t3_next", base + 1);
        if (log_words.size() >= base + 1)
            check_eq("t3_next_toggle", log_words[base][13], 0);

        // Stall during an X word
        out_ready = 1'b0;
        push_req('{3, 4'b0010, 0, 0, 0, 1023, 0, 0});
        wait_wr_en("t4_wr_en");
        base = log_words.size();
        repeat (5) begin
            @(negedge clk); #1;
            check_eq("t4_stall_wr_en", wr_en, 1);
            check_eq("t4_stall_data", writedata, 32'h0C0283FF);
        end
        check_eq("t4_no_accept", log_words.size(), base);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_words("t4_release", base + 1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("t4_single", log_words.size(), base + 1);
        if (log_words.size() >= base + 1)
            check_eq("t4_word", log_words[base], 32'h0C0283FF);

        // Commit stalled: FIFO fills, second pulse coalesces and flags overrun
        out_ready = 1'b0;
        c0 = n_commits;
        pulse_frame();
        wait_wr_en("t5_commit_wr_en");
        check_eq("t5_commit_word", writedata, 32'h001E0000);
        pulse_frame();
        np0 = n_pushed;
        for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
            r = rand_req();
            r.comp = 16 + i;
            r.mask = (i % 15) + 1;
            drive_req(r);
            req_valid = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        @(negedge clk); #1;
        check_eq("t5_accepted", n_pushed - np0, FIFO_DEPTH);
        check_eq("t5_ready_low", req_ready, 0);
        check_eq("t6_overrun", commit_overrun, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle("t5_drain");
        check_eq("t6_one_commit", n_commits - c0, 1);
        check_eq("t6_back_sel", back_sel, 1);
`ifdef SPRITE_CMD_STATS_EN
        check_eq("stat_frames", stat_frames, 16'(n_commits));
`endif

        // Randomised traffic
        for (int k = 0; k < 800; k++) begin
            @(posedge clk); #1;
            if (req_valid && ready_s) req_valid = 1'b0;
            if (!req_valid && ($urandom % 3) == 0) begin
                drive_req(rand_req());
                req_valid = 1'b1;
            end
            out_ready   = ($urandom % 4) != 0;
            frame_start = ($urandom % 50) == 0;
        end
        frame_start = 1'b0;
        for (int k = 0; k < 300 && req_valid; k++) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            if (req_valid && ready_s) req_valid = 1'b0;
        end
        check_eq("rand_push_done", req_valid, 0);
        out_ready = 1'b1;
        wait_idle("rand_drain");
        check_eq("final_reqs_left", pending_reqs(), 0);
        check_eq("final_pending", m_pending, 0);
        check_eq("final_overrun", commit_overrun, m_overrun);
`ifdef SPRITE_CMD_STATS_EN
        check_eq("final_stat_frames", stat_frames, 16'(n_commits));
        check_eq("final_stat_words", stat_words, 16'(log_words.size()));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
